// File: rtl/btn_cond_pkg.sv
// Shared width helpers and types for the btn_conditioner push-button block.
// Repeat-related types are only used when BTN_COND_HOLD_REPEAT_EN is defined.
package btn_cond_pkg;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned width_for(input int unsigned n);
        return (n <= 2) ? 1 : int'($clog2(n));
    endfunction

    function automatic int unsigned mode_width(input int unsigned nmodes);
        return width_for(nmodes);
    endfunction

    function automatic int unsigned db_cnt_width(input int unsigned debounce_ticks);
        return width_for(debounce_ticks);
    endfunction

    function automatic int unsigned rep_cnt_width(input int unsigned delay_ticks,
                                                  input int unsigned rate_ticks);
        return width_for((delay_ticks > rate_ticks) ? delay_ticks : rate_ticks);
    endfunction

    typedef enum logic {
        REP_DELAY,
        REP_RATE
    } rep_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, tick debounce, press/release pulses, toggle, mode counter.
// Hold auto-repeat is built only when BTN_COND_HOLD_REPEAT_EN is defined.
module btn_channel
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS     = 20,
    parameter int unsigned NMODES             = 3,
    parameter int unsigned REPEAT_DELAY_TICKS = 500,
    parameter int unsigned REPEAT_RATE_TICKS  = 100,
    parameter int unsigned MW                 = mode_width(NMODES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          btn_in,
    input  logic          mode_clr,
    output logic          btn_level,
    output logic          btn_press,
    output logic          btn_release,
    output logic          btn_toggle,
    output logic [MW-1:0] mode_sel
);

    localparam int unsigned      DW        = db_cnt_width(DEBOUNCE_TICKS);
    localparam logic [DW-1:0]    DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [MW-1:0]    MODE_LAST = MW'(NMODES - 1);

    if (DEBOUNCE_TICKS < 1 || NMODES < 2 || REPEAT_DELAY_TICKS < 1 || REPEAT_RATE_TICKS < 1)
    begin : g_param_check
        $error("btn_channel: invalid parameter value");
    end

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] db_cnt;
    logic          level_q;
    logic          edge_press;
    logic          rep_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt    <= '0;
            btn_level <= 1'b0;
        end else if (tick) begin
            if (sync2 == btn_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_level <= sync2;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Pulses appear the cycle after btn_level moves; repeats share the press output.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q     <= 1'b0;
            edge_press  <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            level_q     <= btn_level;
            edge_press  <= btn_level & ~level_q;
            btn_press   <= (btn_level & ~level_q) | rep_hit;
            btn_release <= ~btn_level & level_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || mode_clr) begin
            mode_sel   <= '0;
            btn_toggle <= 1'b0;
        end else begin
            if (btn_press)
                mode_sel <= (mode_sel == MODE_LAST) ? '0 : mode_sel + 1'b1;
            if (edge_press)
                btn_toggle <= ~btn_toggle;
        end
    end

`ifdef BTN_COND_HOLD_REPEAT_EN
    localparam int unsigned   RW         = rep_cnt_width(REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_TICKS - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_TICKS - 1);

    rep_state_e    rep_state;
    rep_state_e    rep_state_nxt;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset || mode_clr || !btn_level) begin
            rep_state <= REP_DELAY;
            rep_cnt   <= '0;
        end else begin
            rep_state <= rep_state_nxt;
            rep_cnt   <= rep_cnt_nxt;
        end
    end

    always_comb begin
        rep_state_nxt = rep_state;
        rep_cnt_nxt   = rep_cnt;
        rep_hit       = 1'b0;
        if (tick && btn_level) begin
            case (rep_state)
                REP_DELAY: begin
                    if (rep_cnt == DELAY_LAST) begin
                        rep_hit       = 1'b1;
                        rep_cnt_nxt   = '0;
                        rep_state_nxt = REP_RATE;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 1'b1;
                    end
                end
                REP_RATE: begin
                    if (rep_cnt == RATE_LAST) begin
                        rep_hit     = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 1'b1;
                    end
                end
                default: rep_state_nxt = REP_DELAY;
            endcase
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: shared tick prescaler plus NCH btn_channel instances.
// Define BTN_COND_HOLD_REPEAT_EN to build hold auto-repeat into every channel.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int unsigned CLK_HZ             = 100_000_000,
    parameter int unsigned TICK_HZ            = 1000,
    parameter int unsigned NCH                = 4,
    parameter int unsigned DEBOUNCE_TICKS     = 20,
    parameter int unsigned NMODES             = 3,
    parameter int unsigned REPEAT_DELAY_TICKS = 500,
    parameter int unsigned REPEAT_RATE_TICKS  = 100,
    localparam int unsigned MW                = mode_width(NMODES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    btn_in,
    input  logic [NCH-1:0]    mode_clr,
    output logic              tick,
    output logic [NCH-1:0]    btn_level,
    output logic [NCH-1:0]    btn_press,
    output logic [NCH-1:0]    btn_release,
    output logic [NCH-1:0]    btn_toggle,
    output logic [NCH*MW-1:0] mode_sel
);

    localparam int unsigned   TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned   PW       = width_for(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2 || NCH < 1) begin : g_param_check
        $error("btn_conditioner: invalid parameter value");
    end

    logic [PW-1:0] pre_cnt;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset || tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_TICKS     (DEBOUNCE_TICKS),
            .NMODES             (NMODES),
            .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
            .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS),
            .MW                 (MW)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .tick        (tick),
            .btn_in      (btn_in[i]),
            .mode_clr    (mode_clr[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_toggle  (btn_toggle[i]),
            .mode_sel    (mode_sel[i*MW +: MW])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: TICK_DIV=10, DEBOUNCE_TICKS=3, NMODES=3, NCH=2, repeat 5/2.
// With BTN_COND_HOLD_REPEAT_EN defined the hold phase expects auto-repeat presses.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn_in = '0;
    logic [1:0] mode_clr = '0;
    logic       tick;
    logic [1:0] btn_level, btn_press, btn_release, btn_toggle;
    logic [3:0] mode_sel;

    btn_conditioner #(
        .CLK_HZ             (1000),
        .TICK_HZ            (100),
        .NCH                (2),
        .DEBOUNCE_TICKS     (3),
        .NMODES             (3),
        .REPEAT_DELAY_TICKS (5),
        .REPEAT_RATE_TICKS  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .mode_clr    (mode_clr),
        .tick        (tick),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_toggle  (btn_toggle),
        .mode_sel    (mode_sel)
    );

    always #5 clk = ~clk;

    // Clock index since reset release: first cycle after the last reset edge is 0.
    int cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        int         at;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] level;
        logic [1:0] tog;
        logic [3:0] mode;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endfunction

    task automatic expect_ev(input int at, input logic [1:0] p, input logic [1:0] r,
                             input logic [1:0] l, input logic [1:0] t, input logic [3:0] m);
        ev_t e;
        e.at = at; e.press = p; e.rel = r; e.level = l; e.tog = t; e.mode = m;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            errors++;
            checks++;
            $display("FAIL wait_cyc: reached %0d expected %0d", cyc, n);
        end
    endtask

    task automatic check_reset_state();
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_level", 32'(btn_level), 32'd0);
        check("rst_press", 32'(btn_press), 32'd0);
        check("rst_release", 32'(btn_release), 32'd0);
        check("rst_toggle", 32'(btn_toggle), 32'd0);
        check("rst_mode", 32'(mode_sel), 32'd0);
    endtask

    task automatic do_reset();
        check("events_pending_before_reset", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        check_reset_state();
    endtask

    // Monitor: tick cadence every cycle, and every press/release pulse against the queue.
    ev_t pend_ev;
    bit  pend = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            check("tick", 32'(tick), 32'((cyc % 10) == 9));
            if (pend) begin
                check("toggle_after", 32'(btn_toggle), 32'(pend_ev.tog));
                check("mode_after", 32'(mode_sel), 32'(pend_ev.mode));
                pend = 1'b0;
            end
            if (btn_press != 2'b00 || btn_release != 2'b00) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event @cyc %0d: press %b release %b expected none",
                             cyc, btn_press, btn_release);
                end else begin
                    pend_ev = exp_q.pop_front();
                    check("event_cycle", 32'(cyc), 32'(pend_ev.at));
                    check("press", 32'(btn_press), 32'(pend_ev.press));
                    check("release", 32'(btn_release), 32'(pend_ev.rel));
                    check("level", 32'(btn_level), 32'(pend_ev.level));
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] mode_tab [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    logic       tog_tab  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        repeat (5) @(negedge clk);
        reset = 1'b0;
        check_reset_state();

        // Phase A: clean press/release, then a sub-debounce glitch.
        wait_cyc(20);  btn_in[0] = 1'b1;
        expect_ev(51, 2'b01, 2'b00, 2'b01, 2'b01, 4'b0001);
        wait_cyc(70);  btn_in[0] = 1'b0;
        expect_ev(101, 2'b00, 2'b01, 2'b00, 2'b01, 4'b0001);
        wait_cyc(150); btn_in[0] = 1'b1;
        wait_cyc(165); btn_in[0] = 1'b0;
        wait_cyc(200);
        check("glitch_level", 32'(btn_level), 32'd0);
        check("glitch_mode", 32'(mode_sel), 32'b0001);
        do_reset();

        // Phase B: four presses on ch0, mode wraps and toggle alternates.
        for (int i = 0; i < 4; i++) begin
            wait_cyc(20 + 100 * i);
            btn_in[0] = 1'b1;
            expect_ev(51 + 100 * i, 2'b01, 2'b00, 2'b01, {1'b0, tog_tab[i]}, {2'b00, mode_tab[i]});
            wait_cyc(70 + 100 * i);
            btn_in[0] = 1'b0;
            expect_ev(101 + 100 * i, 2'b00, 2'b01, 2'b00, {1'b0, tog_tab[i]}, {2'b00, mode_tab[i]});
        end
        wait_cyc(450);
        do_reset();

        // Phase C: ch1 press, then joint press with mode_clr[1] in the press cycle.
        wait_cyc(20);  btn_in[1] = 1'b1;
        expect_ev(51, 2'b10, 2'b00, 2'b10, 2'b10, 4'b0100);
        wait_cyc(70);  btn_in[1] = 1'b0;
        expect_ev(101, 2'b00, 2'b10, 2'b00, 2'b10, 4'b0100);
        wait_cyc(120); btn_in = 2'b11;
        expect_ev(151, 2'b11, 2'b00, 2'b11, 2'b01, 4'b0001);
        wait_cyc(151); mode_clr = 2'b10;
        wait_cyc(152); mode_clr = 2'b00;
        wait_cyc(170); btn_in = 2'b00;
        expect_ev(201, 2'b00, 2'b11, 2'b00, 2'b01, 4'b0001);

        // Hold ch0 for 12 ticks after acceptance (level rises at 250, falls at 370).
        wait_cyc(220); btn_in[0] = 1'b1;
        expect_ev(251, 2'b01, 2'b00, 2'b01, 2'b00, 4'b0010);
`ifdef BTN_COND_HOLD_REPEAT_EN
        expect_ev(300, 2'b01, 2'b00, 2'b01, 2'b00, 4'b0000);
        expect_ev(320, 2'b01, 2'b00, 2'b01, 2'b00, 4'b0001);
        expect_ev(340, 2'b01, 2'b00, 2'b01, 2'b00, 4'b0010);
        expect_ev(360, 2'b01, 2'b00, 2'b01, 2'b00, 4'b0000);
        wait_cyc(340); btn_in[0] = 1'b0;
        expect_ev(371, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000);
`else
        wait_cyc(340); btn_in[0] = 1'b0;
        expect_ev(371, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0010);
`endif
        wait_cyc(420);
        check("events_missing", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
